// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: FSM state encoding and run-mode constants.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle between a timer client (master) and timer_ctrl (slave).
// start is a request sampled every clk; it is accepted only in IDLE with stop low and
// period != 0, rejected with a one-cycle err when period == 0, and ignored in RUN.
interface timer_ctrl_if #(
  parameter int CW = 16
);
  import timer_pkg::*;

  logic          start;
  logic          stop;
  logic          mode;
  logic [CW-1:0] period;
  logic          busy;
  logic          tick;
  logic          expire;
  logic          err;
  logic [CW-1:0] count;
  state_e        dbg_state;

  modport master (
    output start, stop, mode, period,
    input  busy, tick, expire, err, count, dbg_state
  );

  modport slave (
    input  start, stop, mode, period,
    output busy, tick, expire, err, count, dbg_state
  );

endinterface

// File: rtl/timer_ctrl_prescaler.sv
// Free-running divide-by-PRESCALE counter with a registered pulse on each wrap to 0.
module prescaler #(
  parameter  int PRESCALE = 100,
  localparam int QW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [QW-1:0] q,
  output logic          wrap
);

  localparam logic [QW-1:0] LAST = QW'(PRESCALE - 1);

  logic [QW-1:0] q_q, q_d;
  logic          wrap_q, wrap_d;

  // clr wins over en so an abort can never emit a wrap on the same edge.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      if (q_q == LAST) begin
        q_d    = '0;
        wrap_d = 1'b1;
      end else begin
        q_d = q_q + QW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/timer_ctrl.sv
// Tick-based timer: one-shot or periodic timeout of `period` ticks, each tick PRESCALE clks.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = 100,
  parameter int CW       = 16
) (
  input logic          clk,
  input logic          rst,
  timer_ctrl_if.slave  bus
);

  localparam int            QW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [QW-1:0] LAST = QW'(PRESCALE - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] count_q, count_d;
  logic          mode_q, mode_d;
  logic          expire_q, expire_d;
  logic          err_q, err_d;
  logic          accept, abort;
  logic [QW-1:0] pre_q;
  logic          pre_wrap;

  prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == RUN),
    .clr  (accept || abort),
    .q    (pre_q),
    .wrap (pre_wrap)
  );

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    mode_d   = mode_q;
    count_d  = count_q;
    expire_d = 1'b0;
    err_d    = 1'b0;
    accept   = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.period == '0) begin
            err_d = 1'b1;
          end else begin
            accept   = 1'b1;
            period_d = bus.period;
            mode_d   = bus.mode;
            count_d  = '0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          abort   = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end else if (pre_q == LAST) begin
          // This edge is a tick: the prescaler wraps and emits tick alongside.
          if (count_q == period_q - CW'(1)) begin
            count_d  = '0;
            expire_d = 1'b1;
            if (mode_q == MODE_ONESHOT) state_d = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      count_q  <= '0;
      expire_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      expire_q <= expire_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.tick      = pre_wrap;
  assign bus.expire    = expire_q;
  assign bus.err       = err_q;
  assign bus.count     = count_q;
  assign bus.dbg_state = state_q;

endmodule
